// File: rtl/axis_rate_meter.sv
// axis_rate_meter: passive AXI-Stream tap that measures bytes, beats, frames
// and stall cycles over a programmable window of clock cycles, publishing
// saturating totals once per completed window.
module axis_rate_meter #(
  parameter int DATA_WIDTH   = 64,
  parameter bit KEEP_ENABLE  = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH   = (DATA_WIDTH / 8),
  parameter bit LAST_ENABLE  = 1'b1,
  parameter int WINDOW_WIDTH = 16,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [KEEP_WIDTH-1:0]   monitor_axis_tkeep,
  input  logic                    monitor_axis_tvalid,
  input  logic                    monitor_axis_tready,
  input  logic                    monitor_axis_tlast,
  input  logic [WINDOW_WIDTH-1:0] window_len,
  output logic [COUNT_WIDTH-1:0]  byte_count,
  output logic [COUNT_WIDTH-1:0]  beat_count,
  output logic [COUNT_WIDTH-1:0]  frame_count,
  output logic [COUNT_WIDTH-1:0]  stall_count,
  output logic                    stats_valid,
  output logic                    busy
);

  // BW holds the largest per-cycle increment (a full tkeep popcount)
  localparam int BW = $clog2(KEEP_WIDTH + 1);
  localparam int SW = COUNT_WIDTH + BW;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                   state_q, state_d;
  logic [WINDOW_WIDTH-1:0]  len_q, len_d;
  logic [WINDOW_WIDTH-1:0]  cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0]   acc_byte_q, acc_byte_d, acc_beat_q, acc_beat_d;
  logic [COUNT_WIDTH-1:0]   acc_frame_q, acc_frame_d, acc_stall_q, acc_stall_d;
  logic [COUNT_WIDTH-1:0]   out_byte_q, out_byte_d, out_beat_q, out_beat_d;
  logic [COUNT_WIDTH-1:0]   out_frame_q, out_frame_d, out_stall_q, out_stall_d;
  logic                     stats_q, stats_d;

  logic                     xfer, stall, frame;
  logic [BW-1:0]            pop, byte_ev;
  logic [COUNT_WIDTH-1:0]   nxt_byte, nxt_beat, nxt_frame, nxt_stall;
  logic                     win_end;

  // Saturating add: anything that overflows COUNT_WIDTH pins at all-ones
  function automatic logic [COUNT_WIDTH-1:0] sat_add(
    input logic [COUNT_WIDTH-1:0] a,
    input logic [BW-1:0]          b
  );
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (|s[SW-1:COUNT_WIDTH]) return '1;
    return s[COUNT_WIDTH-1:0];
  endfunction

  assign xfer  = monitor_axis_tvalid & monitor_axis_tready;
  assign stall = monitor_axis_tvalid & ~monitor_axis_tready;
  assign frame = xfer & (LAST_ENABLE ? monitor_axis_tlast : 1'b1);

  // Byte count per beat is the number of asserted keep lanes
  always_comb begin
    pop = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) pop = pop + BW'(monitor_axis_tkeep[i]);
  end

  assign byte_ev   = xfer ? (KEEP_ENABLE ? pop : BW'(KEEP_WIDTH)) : '0;
  assign nxt_byte  = sat_add(acc_byte_q,  byte_ev);
  assign nxt_beat  = sat_add(acc_beat_q,  BW'(xfer));
  assign nxt_frame = sat_add(acc_frame_q, BW'(frame));
  assign nxt_stall = sat_add(acc_stall_q, BW'(stall));
  assign win_end   = (state_q == S_RUN) && (cnt_q == len_q - WINDOW_WIDTH'(1));

  // Next-state: window sequencing, accumulation and publish on window end
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_byte_d  = acc_byte_q;
    acc_beat_d  = acc_beat_q;
    acc_frame_d = acc_frame_q;
    acc_stall_d = acc_stall_q;
    out_byte_d  = out_byte_q;
    out_beat_d  = out_beat_q;
    out_frame_d = out_frame_q;
    out_stall_d = out_stall_q;
    stats_d     = 1'b0;
    if (state_q == S_IDLE) begin
      // Idle ignores traffic; the entering cycle is not part of any window
      cnt_d       = '0;
      acc_byte_d  = '0;
      acc_beat_d  = '0;
      acc_frame_d = '0;
      acc_stall_d = '0;
      if (window_len != '0) begin
        state_d = S_RUN;
        len_d   = window_len;
      end
    end else if (win_end) begin
      // Last cycle's own event is folded into the published totals
      out_byte_d  = nxt_byte;
      out_beat_d  = nxt_beat;
      out_frame_d = nxt_frame;
      out_stall_d = nxt_stall;
      acc_byte_d  = '0;
      acc_beat_d  = '0;
      acc_frame_d = '0;
      acc_stall_d = '0;
      cnt_d       = '0;
      len_d       = window_len;
      stats_d     = 1'b1;
      if (window_len == '0) state_d = S_IDLE;
    end else begin
      acc_byte_d  = nxt_byte;
      acc_beat_d  = nxt_beat;
      acc_frame_d = nxt_frame;
      acc_stall_d = nxt_stall;
      cnt_d       = cnt_q + WINDOW_WIDTH'(1);
    end
  end

  // State register; reset discards any partial window and clears outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_byte_q  <= '0;
      acc_beat_q  <= '0;
      acc_frame_q <= '0;
      acc_stall_q <= '0;
      out_byte_q  <= '0;
      out_beat_q  <= '0;
      out_frame_q <= '0;
      out_stall_q <= '0;
      stats_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_byte_q  <= acc_byte_d;
      acc_beat_q  <= acc_beat_d;
      acc_frame_q <= acc_frame_d;
      acc_stall_q <= acc_stall_d;
      out_byte_q  <= out_byte_d;
      out_beat_q  <= out_beat_d;
      out_frame_q <= out_frame_d;
      out_stall_q <= out_stall_d;
      stats_q     <= stats_d;
    end
  end

  assign byte_count  = out_byte_q;
  assign beat_count  = out_beat_q;
  assign frame_count = out_frame_q;
  assign stall_count = out_stall_q;
  assign stats_valid = stats_q;
  assign busy        = (state_q == S_RUN);

endmodule

// File: tb/tb_axis_rate_meter.sv
// Directed bench for axis_rate_meter: a default-width instance plus a
// COUNT_WIDTH=4 instance sharing the same tap, for saturation checks.
module tb_axis_rate_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tkeep;
  logic        tvalid, tready, tlast;
  logic [15:0] wlen;
  logic [31:0] byte_c, beat_c, frame_c, stall_c;
  logic        sv, busy;
  logic [3:0]  byte_s, beat_s, frame_s, stall_s;
  logic        sv_s, busy_s;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  axis_rate_meter dut (
    .clk(clk), .rst(rst),
    .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast),
    .window_len(wlen),
    .byte_count(byte_c), .beat_count(beat_c), .frame_count(frame_c),
    .stall_count(stall_c), .stats_valid(sv), .busy(busy)
  );

  axis_rate_meter #(.COUNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst),
    .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast),
    .window_len(wlen),
    .byte_count(byte_s), .beat_count(beat_s), .frame_count(frame_s),
    .stall_count(stall_s), .stats_valid(sv_s), .busy(busy_s)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tvalid = 1'b1; tready = 1'b1; tkeep = 8'hFF; tlast = 1'b1;
    wlen = 16'd4;
    repeat (3) tick();
    vec++; if (byte_c !== 32'd0)  begin err++; $display("FAIL reset_byte: got %0d want 0", byte_c); end
    vec++; if (beat_c !== 32'd0)  begin err++; $display("FAIL reset_beat: got %0d want 0", beat_c); end
    vec++; if (frame_c !== 32'd0) begin err++; $display("FAIL reset_frame: got %0d want 0", frame_c); end
    vec++; if (stall_c !== 32'd0) begin err++; $display("FAIL reset_stall: got %0d want 0", stall_c); end
    vec++; if (sv !== 1'b0)       begin err++; $display("FAIL reset_sv: got %0b want 0", sv); end
    vec++; if (busy !== 1'b0)     begin err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vec++; if (beat_s !== 4'd0 || busy_s !== 1'b0) begin err++; $display("FAIL reset_small: got beat %0d busy %0b want 0 0", beat_s, busy_s); end
    rst = 1'b0; tvalid = 1'b0; wlen = 16'd0;
    tick();
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_full_rate();
    apply_reset();
    wlen = 16'd8; tvalid = 1'b1; tready = 1'b1; tkeep = 8'hFF; tlast = 1'b0;
    tick();  // IDLE -> RUN edge, traffic not counted
    vec++; if (busy !== 1'b1 || sv !== 1'b0) begin err++; $display("FAIL full_enter: got busy %0b sv %0b want 1 0", busy, sv); end
    for (int j = 0; j < 16; j++) begin
      tlast = (j % 4 == 3);
      tick();
      vec++; if (sv !== (j % 8 == 7)) begin err++; $display("FAIL full_sv[%0d]: got %0b want %0b", j, sv, (j % 8 == 7)); end
      if (j == 7) begin
        vec++; if (byte_c !== 32'd64) begin err++; $display("FAIL full_byte: got %0d want 64", byte_c); end
        vec++; if (beat_c !== 32'd8)  begin err++; $display("FAIL full_beat: got %0d want 8", beat_c); end
        vec++; if (frame_c !== 32'd2) begin err++; $display("FAIL full_frame: got %0d want 2", frame_c); end
        vec++; if (stall_c !== 32'd0) begin err++; $display("FAIL full_stall: got %0d want 0", stall_c); end
        vec++; if (beat_s !== 4'd8 || frame_s !== 4'd2) begin err++; $display("FAIL full_small: got beat %0d frame %0d want 8 2", beat_s, frame_s); end
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    wlen = 16'd10; tvalid = 1'b1; tready = 1'b1; tkeep = 8'h0F; tlast = 1'b0;
    tick();
    for (int j = 0; j < 10; j++) begin
      tready = (j % 2 == 0);
      tick();
    end
    vec++; if (sv !== 1'b1)       begin err++; $display("FAIL stall_sv: got %0b want 1", sv); end
    vec++; if (beat_c !== 32'd5)  begin err++; $display("FAIL stall_beat: got %0d want 5", beat_c); end
    vec++; if (byte_c !== 32'd20) begin err++; $display("FAIL stall_byte: got %0d want 20", byte_c); end
    vec++; if (stall_c !== 32'd5) begin err++; $display("FAIL stall_stall: got %0d want 5", stall_c); end
    vec++; if (frame_c !== 32'd0) begin err++; $display("FAIL stall_frame: got %0d want 0", frame_c); end
  endtask

  task automatic test_saturate();
    apply_reset();
    wlen = 16'd20; tvalid = 1'b1; tready = 1'b1; tkeep = 8'hFF; tlast = 1'b0;
    tick();
    repeat (20) tick();
    vec++; if (sv_s !== 1'b1)     begin err++; $display("FAIL sat_sv: got %0b want 1", sv_s); end
    vec++; if (byte_s !== 4'd15)  begin err++; $display("FAIL sat_byte: got %0d want 15", byte_s); end
    vec++; if (beat_s !== 4'd15)  begin err++; $display("FAIL sat_beat: got %0d want 15", beat_s); end
    vec++; if (beat_c !== 32'd20) begin err++; $display("FAIL wide_beat: got %0d want 20", beat_c); end
    vec++; if (byte_c !== 32'd160) begin err++; $display("FAIL wide_byte: got %0d want 160", byte_c); end
  endtask

  task automatic test_len_change();
    apply_reset();
    wlen = 16'd8; tvalid = 1'b1; tready = 1'b1; tkeep = 8'hFF; tlast = 1'b0;
    tick();
    for (int j = 0; j < 8; j++) begin
      if (j == 3) wlen = 16'd4;
      tick();
      vec++; if (sv !== (j == 7)) begin err++; $display("FAIL chg8_sv[%0d]: got %0b want %0b", j, sv, (j == 7)); end
    end
    vec++; if (beat_c !== 32'd8) begin err++; $display("FAIL chg8_beat: got %0d want 8", beat_c); end
    wlen = 16'd0;  // latched at the end of the 4-cycle window
    for (int j = 0; j < 4; j++) begin
      tick();
      vec++; if (sv !== (j == 3)) begin err++; $display("FAIL chg4_sv[%0d]: got %0b want %0b", j, sv, (j == 3)); end
    end
    vec++; if (beat_c !== 32'd4 || byte_c !== 32'd32) begin err++; $display("FAIL chg4_cnt: got beat %0d byte %0d want 4 32", beat_c, byte_c); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL stop_busy: got %0b want 0", busy); end
    repeat (3) tick();
    vec++; if (sv !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL stop_idle: got sv %0b busy %0b want 0 0", sv, busy); end
    vec++; if (beat_c !== 32'd4 || byte_c !== 32'd32) begin err++; $display("FAIL stop_hold: got beat %0d byte %0d want 4 32", beat_c, byte_c); end
  endtask

  // Starts from the held 4/32 results of the previous test
  task automatic test_reset_mid();
    wlen = 16'd8; tvalid = 1'b1; tready = 1'b1; tkeep = 8'hFF; tlast = 1'b1;
    tick();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++; if (beat_c !== 32'd0 || byte_c !== 32'd0 || frame_c !== 32'd0) begin err++; $display("FAIL rstmid_cnt: got beat %0d byte %0d frame %0d want 0 0 0", beat_c, byte_c, frame_c); end
    vec++; if (sv !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL rstmid_flags: got sv %0b busy %0b want 0 0", sv, busy); end
    tick();  // re-enter RUN
    for (int j = 0; j < 8; j++) begin
      tick();
      vec++; if (sv !== (j == 7)) begin err++; $display("FAIL rstmid_sv[%0d]: got %0b want %0b", j, sv, (j == 7)); end
    end
    vec++; if (beat_c !== 32'd8 || byte_c !== 32'd64 || frame_c !== 32'd8) begin err++; $display("FAIL rstmid_win: got beat %0d byte %0d frame %0d want 8 64 8", beat_c, byte_c, frame_c); end
  endtask

  task automatic test_len_one();
    apply_reset();
    wlen = 16'd1; tvalid = 1'b0; tready = 1'b1; tkeep = 8'hFF; tlast = 1'b0;
    tick();
    tvalid = 1'b1; tlast = 1'b1;
    tick();
    vec++; if (sv !== 1'b1) begin err++; $display("FAIL one_sv: got %0b want 1", sv); end
    vec++; if (beat_c !== 32'd1 || frame_c !== 32'd1 || byte_c !== 32'd8) begin err++; $display("FAIL one_cnt: got beat %0d frame %0d byte %0d want 1 1 8", beat_c, frame_c, byte_c); end
    tvalid = 1'b0; tlast = 1'b0;
    tick();
    vec++; if (sv !== 1'b1 || beat_c !== 32'd0 || frame_c !== 32'd0) begin err++; $display("FAIL one_zero: got sv %0b beat %0d frame %0d want 1 0 0", sv, beat_c, frame_c); end
    tvalid = 1'b1; tready = 1'b1; tkeep = 8'h00;
    tick();
    vec++; if (beat_c !== 32'd1 || byte_c !== 32'd0) begin err++; $display("FAIL one_nokeep: got beat %0d byte %0d want 1 0", beat_c, byte_c); end
    tready = 1'b0;
    tick();
    vec++; if (stall_c !== 32'd1 || beat_c !== 32'd0 || sv !== 1'b1) begin err++; $display("FAIL one_stall: got stall %0d beat %0d sv %0b want 1 0 1", stall_c, beat_c, sv); end
  endtask

  initial begin
    rst = 1'b1; tkeep = '0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; wlen = '0;
    test_reset();
    test_full_rate();
    test_stall();
    test_saturate();
    test_len_change();
    test_reset_mid();
    test_len_one();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
